// File: rtl/controller_pkg.sv
// controller_pkg: state and datapath-select encodings shared by the main controller FSM
package controller_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;
  localparam logic [1:0] SRCA_REG = 2'b00;
  localparam logic [1:0] SRCA_PC = 2'b01;
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_ALU = 2'b10;
  localparam logic [1:0] OP_DP = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR = 2'b10;
endpackage

// File: rtl/main_controller_fsm.sv
// main_controller_fsm: multicycle fetch/decode/execute sequencer with retired-instruction counter
module main_controller_fsm
  import controller_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             op,
  input  logic [5:0]             funct,
  input  logic                   memory_ready,
  output logic                   instruction_write,
  output logic                   next_pc,
  output logic                   branch,
  output logic                   potential_register_write,
  output logic                   potential_memory_write,
  output logic                   alu_op,
  output logic                   address_source,
  output logic [1:0]             alu_source_a,
  output logic [1:0]             alu_source_b,
  output logic [1:0]             result_source,
  output logic                   undefined_instruction,
  output logic [COUNT_WIDTH-1:0] retired_count
);
  state_t state, state_next;
  logic retire;
  logic unused_funct;
  assign unused_funct = ^funct[4:1];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FETCH;
    else state <= state_next;
  end
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:    state_next = memory_ready ? DECODE : FETCH;
      DECODE:   state_next = op == OP_MEM ? MEMADR :
                             op == OP_DP  ? (funct[5] ? EXECUTEI : EXECUTER) :
                             op == OP_BR  ? BRANCH : FETCH;
      MEMADR:   state_next = funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_next = memory_ready ? MEMWB : MEMRD;
      MEMWR:    state_next = memory_ready ? FETCH : MEMWR;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      default:  state_next = FETCH;
    endcase
  end
  // unknown encodings fall to the all-zero default and recover through state_next
  always_comb begin
    instruction_write = 1'b0;
    next_pc = 1'b0;
    branch = 1'b0;
    potential_register_write = 1'b0;
    potential_memory_write = 1'b0;
    alu_op = 1'b0;
    address_source = 1'b0;
    alu_source_a = SRCA_REG;
    alu_source_b = SRCB_REG;
    result_source = RES_ALUOUT;
    undefined_instruction = 1'b0;
    case (state)
      FETCH: begin
        alu_source_a = SRCA_PC;
        alu_source_b = SRCB_FOUR;
        result_source = RES_ALU;
        instruction_write = memory_ready & ~reset;
        next_pc = memory_ready & ~reset;
      end
      DECODE: begin
        alu_source_a = SRCA_PC;
        alu_source_b = SRCB_FOUR;
        result_source = RES_ALU;
        undefined_instruction = op == 2'b11;
      end
      MEMADR:   alu_source_b = SRCB_IMM;
      MEMRD:    address_source = 1'b1;
      MEMWB: begin
        result_source = RES_MEM;
        potential_register_write = 1'b1;
      end
      MEMWR: begin
        address_source = 1'b1;
        potential_memory_write = 1'b1;
      end
      EXECUTER: alu_op = 1'b1;
      EXECUTEI: begin
        alu_source_b = SRCB_IMM;
        alu_op = 1'b1;
      end
      ALUWB:    potential_register_write = 1'b1;
      BRANCH: begin
        alu_source_b = SRCB_IMM;
        result_source = RES_ALU;
        branch = 1'b1;
      end
      default: ;
    endcase
  end
  assign retire = state == MEMWB || state == ALUWB || state == BRANCH ||
                  (state == MEMWR && memory_ready);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) retired_count <= '0;
    else if (retire) retired_count <= retired_count + 1'b1;
  end
endmodule
